// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and layout constants for the instruction packer
package instr_pkg;

    localparam int IR_W    = 4;
    localparam int OP_W    = 8;
    localparam int ADDR_W  = 20;
    localparam int HALF_W  = 32;
    localparam int WORD_W  = 64;

    localparam int NAT_HALF_W     = 32;
    localparam int BESM_HALF_W    = 24;
    localparam int NAT_LEFT_LSB   = 32;
    localparam int BESM_LEFT_LSB  = 24;
    localparam int BESM_LONG_OP_W   = 4;
    localparam int BESM_LONG_ADDR_W = 15;
    localparam int BESM_SHORT_OP_W  = 7;
    localparam int BESM_SHORT_ADDR_W = 12;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [OP_W-1:0]   op;
        logic              extop;
        logic [ADDR_W-1:0] addr;
    } instr_fields_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } packer_state_e;

    // BESM-6 words use only the low 48 bits; the top 16 stay zero.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic              besm,
        input logic [HALF_W-1:0] left,
        input logic [HALF_W-1:0] right
    );
        if (besm) begin
            return {16'h0000, left[BESM_HALF_W-1:0], right[BESM_HALF_W-1:0]};
        end
        return {left, right};
    endfunction

endpackage

// File: rtl/instr_half_encode.sv
// rtl/instr_half_encode.sv - packs one instruction's fields into a half-word
module instr_half_encode
    import instr_pkg::*;
(
    input  instr_fields_t      fields,
    input  logic               pe,
    output logic [HALF_W-1:0]  half,
    output logic               overflow
);

    always_comb begin
        half     = '0;
        overflow = 1'b0;
        if (!pe) begin
            half = {fields.ir, fields.op, fields.addr};
        end else if (fields.extop) begin
            half[BESM_HALF_W-1:0] = {fields.ir, 1'b1,
                                     fields.op[BESM_LONG_OP_W-1:0],
                                     fields.addr[BESM_LONG_ADDR_W-1:0]};
            overflow = (|fields.op[OP_W-1:BESM_LONG_OP_W])
                     | (|fields.addr[ADDR_W-1:BESM_LONG_ADDR_W]);
        end else begin
            half[BESM_HALF_W-1:0] = {fields.ir, 1'b0,
                                     fields.op[BESM_SHORT_OP_W-1:0],
                                     fields.addr[BESM_SHORT_ADDR_W-1:0]};
            overflow = fields.op[OP_W-1]
                     | (|fields.addr[ADDR_W-1:BESM_SHORT_ADDR_W]);
        end
    end

endmodule

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs two instruction halves into a 64-bit word with valid/ready on both sides
module instr_packer
    import instr_pkg::*;
#(
    parameter logic [31:0] NOP_NATIVE = 32'h0000_0000,
    parameter logic [23:0] NOP_BESM   = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pe,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   ir,
    input  logic [OP_W-1:0]   op,
    input  logic              extop,
    input  logic [ADDR_W-1:0] addr,
    input  logic              tkk,
    input  logic              flush,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word,
    output logic              err
);

    packer_state_e      state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               pe_q, pe_d;
    logic               err_q, err_d;

    logic               accept;
    logic               emit;
    logic               start_word;
    logic               cur_pe;
    logic [HALF_W-1:0]  enc_half;
    logic               enc_overflow;
    logic [HALF_W-1:0]  nop_half;
    logic [HALF_W-1:0]  held_left;
    instr_fields_t      fields;

    assign word_valid = (state_q == ST_FULL);
    assign in_ready   = (state_q != ST_FULL) | word_ready;
    assign accept     = in_valid & in_ready;
    assign emit       = word_valid & word_ready;
    assign start_word = accept & (state_q != ST_HALF);
    assign word       = word_q;
    assign err        = err_q;

    // A word in progress keeps the mode it started with; a new word takes pe live.
    assign cur_pe    = (state_q == ST_HALF) ? pe_q : pe;
    assign nop_half  = cur_pe ? {8'h00, NOP_BESM} : NOP_NATIVE;
    assign held_left = pe_q ? {8'h00, word_q[BESM_LEFT_LSB +: BESM_HALF_W]}
                            : word_q[NAT_LEFT_LSB +: NAT_HALF_W];

    always_comb begin
        fields       = '0;
        fields.ir    = ir;
        fields.op    = op;
        fields.extop = extop;
        fields.addr  = addr;
    end

    instr_half_encode u_half_encode (
        .fields   (fields),
        .pe       (cur_pe),
        .half     (enc_half),
        .overflow (enc_overflow)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pe_d    = pe_q;
        err_d   = accept & enc_overflow;

        unique case (state_q)
            ST_EMPTY: ;
            ST_HALF: begin
                if (accept) begin
                    word_d  = pack_word(pe_q, held_left, enc_half);
                    state_d = ST_FULL;
                end else if (flush) begin
                    word_d  = pack_word(pe_q, held_left, nop_half);
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (start_word) begin
            pe_d = pe;
            if (tkk) begin
                word_d  = pack_word(pe, nop_half, enc_half);
                state_d = ST_FULL;
            end else begin
                word_d  = pack_word(pe, enc_half, '0);
                state_d = ST_HALF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            pe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pe_q    <= pe_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// tb/tb_instr_packer.sv - scoreboard bench for instr_packer
module tb_instr_packer;

    logic        clk;
    logic        reset;
    logic        pe;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ir;
    logic [7:0]  op;
    logic        extop;
    logic [19:0] addr;
    logic        tkk;
    logic        flush;
    logic        word_valid;
    logic        word_ready;
    logic [63:0] word;
    logic        err;

    int checks;
    int errors;
    logic [63:0] exp_q[$];

    instr_packer dut (
        .clk        (clk),
        .reset      (reset),
        .pe         (pe),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ir         (ir),
        .op         (op),
        .extop      (extop),
        .addr       (addr),
        .tkk        (tkk),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word       (word),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic p, input logic [3:0] i, input logic [7:0] o,
                                        input logic e, input logic [19:0] a);
        logic [31:0] r;
        if (!p)
            r = (32'(i) << 28) | (32'(o) << 20) | 32'(a);
        else if (e)
            r = (32'(i) << 20) | 32'h0008_0000 | ((32'(o) & 32'hF) << 15) | (32'(a) & 32'h7FFF);
        else
            r = (32'(i) << 20) | ((32'(o) & 32'h7F) << 12) | (32'(a) & 32'hFFF);
        return r;
    endfunction

    function automatic logic ovf(input logic p, input logic [7:0] o, input logic e, input logic [19:0] a);
        if (!p) return 1'b0;
        if (e) return (o > 8'd15) || (a > 20'h07FFF);
        return (o > 8'd127) || (a > 20'h00FFF);
    endfunction

    function automatic logic [63:0] pack(input logic p, input logic [31:0] l, input logic [31:0] r);
        if (p) return (64'(l & 32'hFF_FFFF) << 24) | 64'(r & 32'hFF_FFFF);
        return {l, r};
    endfunction

    task automatic mon_check();
        logic [63:0] exp;
        if (!reset && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: word %h emitted, none expected", word);
            end else begin
                exp = exp_q.pop_front();
                if (word !== exp) begin
                    errors++;
                    $display("FAIL scoreboard_word: got %h, expected %h", word, exp);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic tick();
        #4;
        mon_check();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic p, input logic [3:0] i, input logic [7:0] o,
                        input logic e, input logic [19:0] a, input logic t);
        logic acc;
        logic exp_err;
        int   n;
        pe = p; ir = i; op = o; extop = e; addr = a; tkk = t; in_valid = 1'b1;
        exp_err = ovf(p, o, e, a);
        n = 0;
        forever begin
            #4;
            acc = in_ready;
            mon_check();
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
            n++;
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        tkk = 1'b0;
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_after_accept: got %b, expected %b", err, exp_err);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks += 4;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b, expected 0", word_valid); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b, expected 0", err); end
        if (word !== 64'h0)      begin errors++; $display("FAIL reset_word: got %h, expected 0", word); end
    endtask

    task automatic test_native_pair();
        word_ready = 1'b0;
        send(1'b0, 4'd3, 8'h15, 1'b0, 20'h12345, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL native_half_valid: got %b, expected 0", word_valid); end
        send(1'b0, 4'd4, 8'hA0, 1'b0, 20'h00001, 1'b0);
        exp_q.push_back(64'h3151_2345_4A00_0001);
        checks += 2;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL native_latency: got %b, expected 1", word_valid); end
        if (word !== 64'h3151_2345_4A00_0001) begin
            errors++; $display("FAIL native_word: got %h, expected %h", word, 64'h3151_2345_4A00_0001);
        end
        word_ready = 1'b1;
        tick();
    endtask

    task automatic test_besm();
        logic [31:0] l, r;
        l = enc(1'b1, 4'd2, 8'h05, 1'b1, 20'h01234);
        r = enc(1'b1, 4'd1, 8'h13, 1'b0, 20'h00777);
        send(1'b1, 4'd2, 8'h05, 1'b1, 20'h01234, 1'b0);
        send(1'b1, 4'd1, 8'h13, 1'b0, 20'h00777, 1'b0);
        exp_q.push_back(pack(1'b1, l, r));
        checks++;
        if (word[63:48] !== 16'h0) begin errors++; $display("FAIL besm_upper: got %h, expected 0", word[63:48]); end
        tick();
    endtask

    task automatic test_right_align();
        send(1'b0, 4'd9, 8'h7E, 1'b0, 20'hABCDE, 1'b1);
        exp_q.push_back(pack(1'b0, 32'h0, enc(1'b0, 4'd9, 8'h7E, 1'b0, 20'hABCDE)));
        checks++;
        if (word_valid !== 1'b1) begin errors++; $display("FAIL right_align_valid: got %b, expected 1", word_valid); end
        tick();
    endtask

    task automatic test_flush_backpressure();
        logic [63:0] exp;
        word_ready = 1'b0;
        send(1'b0, 4'd6, 8'h42, 1'b0, 20'h0BEEF, 1'b0);
        do_flush();
        exp = pack(1'b0, enc(1'b0, 4'd6, 8'h42, 1'b0, 20'h0BEEF), 32'h0);
        exp_q.push_back(exp);
        for (int k = 0; k < 5; k++) begin
            checks += 3;
            if (word !== exp)        begin errors++; $display("FAIL hold_word: got %h, expected %h", word, exp); end
            if (in_ready !== 1'b0)   begin errors++; $display("FAIL hold_in_ready: got %b, expected 0", in_ready); end
            if (word_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b, expected 1", word_valid); end
            tick();
        end
        word_ready = 1'b1;
        send(1'b0, 4'd7, 8'h11, 1'b0, 20'h22222, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL bypass_state_half: got %b, expected 0", word_valid); end
        do_flush();
        exp_q.push_back(pack(1'b0, enc(1'b0, 4'd7, 8'h11, 1'b0, 20'h22222), 32'h0));
        tick();
    endtask

    task automatic test_overflow();
        send(1'b1, 4'd5, 8'h22, 1'b0, 20'h01000, 1'b1);
        exp_q.push_back(pack(1'b1, 32'h0, enc(1'b1, 4'd5, 8'h22, 1'b0, 20'h01000)));
        checks++;
        if (word[11:0] !== 12'h000) begin errors++; $display("FAIL ovf_addr_field: got %h, expected 000", word[11:0]); end
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b, expected 0", err); end
        send(1'b1, 4'd1, 8'h15, 1'b1, 20'h00010, 1'b1);
        exp_q.push_back(pack(1'b1, 32'h0, enc(1'b1, 4'd1, 8'h15, 1'b1, 20'h00010)));
        tick();
    endtask

    task automatic test_reset_mid();
        send(1'b0, 4'hF, 8'hFF, 1'b0, 20'hFFFFF, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 2;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", word_valid); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL midreset_in_ready: got %b, expected 1", in_ready); end
        send(1'b0, 4'd1, 8'h02, 1'b0, 20'h00003, 1'b0);
        send(1'b0, 4'd4, 8'h05, 1'b0, 20'h00006, 1'b0);
        exp_q.push_back(pack(1'b0, enc(1'b0, 4'd1, 8'h02, 1'b0, 20'h00003),
                                   enc(1'b0, 4'd4, 8'h05, 1'b0, 20'h00006)));
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  i0, i1;
        logic [7:0]  o0, o1;
        logic        e0, e1, p;
        logic [19:0] a0, a1;
        for (int k = 0; k < 6; k++) begin
            p  = 1'(k % 2);
            i0 = 4'($urandom); o0 = 8'($urandom); e0 = 1'($urandom); a0 = 20'($urandom);
            i1 = 4'($urandom); o1 = 8'($urandom); e1 = 1'($urandom); a1 = 20'($urandom);
            send(p, i0, o0, e0, a0, 1'b0);
            send(p, i1, o1, e1, a1, 1'b0);
            exp_q.push_back(pack(p, enc(p, i0, o0, e0, a0), enc(p, i1, o1, e1, a1)));
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; pe = 1'b0; in_valid = 1'b0; ir = '0; op = '0; extop = 1'b0;
        addr = '0; tkk = 1'b0; flush = 1'b0; word_ready = 1'b1;
        checks = 0; errors = 0;
        @(negedge clk);
        test_reset();
        test_native_pair();
        test_besm();
        test_right_align();
        test_flush_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
